// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register slave: FSM encoding and address map.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_reg_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CMD  = 2'd1;
  localparam state_t S_LOAD = 2'd2;
  localparam state_t S_DATA = 2'd3;

  // Bit of the command byte that selects write (1) or read (0).
  localparam int CMD_WR_BIT = 7;

  localparam logic [6:0] STATUS_ADDR = 7'h0F;
  localparam logic [6:0] CH_STRIDE   = 7'h10;

  // Base address of motor channel c; channel 0 sits at 0x10.
  function automatic logic [6:0] ch_base(input int c);
    return CH_STRIDE * 7'(c + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises one raw SPI pin into theClock and flags its rising edge.
// Latency: STAGES cycles to sync output; rise is combinational off the last stage.
// Backpressure: none; pin is sampled every cycle.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the pin through the synchroniser chain and keep one delayed copy.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], pin};
    prev_d = sync_q[STAGES-1];
  end

  // Synchroniser flops; reset to the pin's idle level so no false edge appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave register bank: config RW bytes, status, per-channel dir/speed with snapshots.
// Latency: pin-to-sample SYNC_STAGES+1 cycles; write commit visible the cycle after the 8th edge.
// Backpressure: none; the master must respect the minimum SPI clock high/low times.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int SPEED_W     = 16,
  parameter int N_CFG       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    theClock,
  input  logic                    theReset_n,
  input  logic                    spi_clk,
  input  logic                    spi_cs,
  input  logic                    spi_sdi,
  output logic                    spi_sdo,
  output logic [N_CFG*8-1:0]      cfg,
  input  logic [7:0]              status,
  input  logic [N_CH*SPEED_W-1:0] speed,
  input  logic [N_CH-1:0]         dir,
  output logic                    wr_strobe,
  output logic [6:0]              wr_addr,
  output logic                    frame_err
);

  localparam int NB = SPEED_W / 8;

  logic clk_sync_unused, clk_rise;
  logic cs_s, cs_rise_unused;
  logic sdi_s, sdi_rise_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(theClock), .rst_n(theReset_n), .pin(spi_clk), .sync(clk_sync_unused), .rise(clk_rise)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(theClock), .rst_n(theReset_n), .pin(spi_cs), .sync(cs_s), .rise(cs_rise_unused)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(theClock), .rst_n(theReset_n), .pin(spi_sdi), .sync(sdi_s), .rise(sdi_rise_unused)
  );

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [7:0]                sr_q, sr_d;
  logic [6:0]                addr_q, addr_d;
  logic                      wr_q, wr_d;
  logic [N_CFG*8-1:0]        cfg_q, cfg_d;
  logic [N_CH*SPEED_W-1:0]   shadow_q, shadow_d;
  logic                      wr_strobe_q, wr_strobe_d;
  logic [6:0]                wr_addr_q, wr_addr_d;
  logic                      frame_err_q, frame_err_d;

  logic [7:0]                rd_byte;
  logic [N_CH-1:0]           snap_sel;
  logic [7:0]                byte_in;

  // Read mux: byte returned for the current address, plus which channel's MSB is being read.
  always_comb begin
    rd_byte  = 8'h00;
    snap_sel = '0;
    for (int k = 0; k < N_CFG; k++) begin
      if (addr_q == 7'(k)) rd_byte = cfg_q[8*k +: 8];
    end
    if (addr_q == STATUS_ADDR) rd_byte = status;
    for (int c = 0; c < N_CH; c++) begin
      if (addr_q == ch_base(c)) rd_byte = {7'b0, dir[c]};
      // MSB comes live from the input; the remaining bytes come from the snapshot it takes.
      if (addr_q == ch_base(c) + 7'd1) begin
        rd_byte     = speed[c*SPEED_W + SPEED_W - 8 +: 8];
        snap_sel[c] = 1'b1;
      end
      for (int k = 1; k < NB; k++) begin
        if (addr_q == ch_base(c) + 7'(k + 1)) rd_byte = shadow_q[c*SPEED_W + SPEED_W - 8 - 8*k +: 8];
      end
    end
  end

  // Frame FSM: command capture, per-byte load/shift, write commit and abort detection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    cfg_d       = cfg_q;
    shadow_d    = shadow_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    byte_in     = {sr_q[6:0], sdi_s};

    // CS release has priority over a coincident SPI edge, so a byte finishing
    // on that same cycle is dropped and reported as an aborted frame.
    if (state_q != S_IDLE && cs_s) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      if ((state_q == S_CMD || state_q == S_DATA) && cnt_q != 3'd0) frame_err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!cs_s) begin
            state_d = S_CMD;
            cnt_d   = 3'd0;
          end
        end
        S_CMD: begin
          if (clk_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              wr_d    = byte_in[CMD_WR_BIT];
              addr_d  = byte_in[6:0];
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          sr_d    = rd_byte;
          state_d = S_DATA;
          for (int c = 0; c < N_CH; c++) begin
            if (snap_sel[c] && !wr_q) shadow_d[c*SPEED_W +: SPEED_W] = speed[c*SPEED_W +: SPEED_W];
          end
        end
        S_DATA: begin
          if (clk_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (wr_q) begin
                for (int k = 0; k < N_CFG; k++) begin
                  if (addr_q == 7'(k)) begin
                    cfg_d[8*k +: 8] = byte_in;
                    wr_strobe_d     = 1'b1;
                    wr_addr_d       = addr_q;
                  end
                end
              end
              addr_d  = addr_q + 7'd1;
              state_d = S_LOAD;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and register storage.
  always_ff @(posedge theClock or negedge theReset_n) begin
    if (!theReset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      sr_q        <= 8'h00;
      addr_q      <= 7'h00;
      wr_q        <= 1'b0;
      cfg_q       <= '0;
      shadow_q    <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      cfg_q       <= cfg_d;
      shadow_q    <= shadow_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi_sdo   = (state_q == S_LOAD || state_q == S_DATA) ? sr_q[7] : 1'b0;
  assign cfg       = cfg_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: bursts, snapshots, wrap, aborted frame, mid-frame reset.
// Latency: SPI half period of 8 system cycles, well above the minimum.
// Backpressure: n/a.
module tb_spi_reg_slave;

  localparam int HALF = 8;

  logic        theClock = 1'b0;
  logic        theReset_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sdi = 1'b0;
  logic        spi_sdo;
  logic [31:0] cfg;
  logic [7:0]  status = 8'h5A;
  logic [31:0] speed = {16'hBEEF, 16'h1234};
  logic [1:0]  dir = 2'b10;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        frame_err;

  spi_reg_slave #(.N_CH(2), .SPEED_W(16), .N_CFG(4), .SYNC_STAGES(2)) dut (
    .theClock(theClock), .theReset_n(theReset_n),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
    .cfg(cfg), .status(status), .speed(speed), .dir(dir),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 theClock = ~theClock;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  int ferr_cnt = 0;
  logic [6:0] addr_log[$];

  // Pulse monitor: counts strobes and frame errors and logs committed addresses.
  always @(negedge theClock) begin
    if (wr_strobe) begin
      strobe_cnt++;
      addr_log.push_back(wr_addr);
    end
    if (frame_err) ferr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge theClock);
  endtask

  task automatic frame_start();
    spi_cs = 1'b0;
    tick(HALF);
  endtask

  task automatic frame_end();
    tick(HALF);
    spi_cs = 1'b1;
    tick(12);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_sdi = tx[7-i];
      tick(HALF);
      spi_clk = 1'b1;
      rx = {rx[6:0], spi_sdo};
      tick(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    xfer_bits(tx, 8, rx);
  endtask

  // Watchdog so a stuck run still terminates with a report.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    int s0, f0;

    tick(3);
    chk("rst_cfg", cfg, 32'h0);
    chk("rst_sdo", {31'b0, spi_sdo}, 32'h0);
    chk("rst_strobe", {31'b0, wr_strobe}, 32'h0);
    chk("rst_wr_addr", {25'b0, wr_addr}, 32'h0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'h0);
    theReset_n = 1'b1;
    tick(5);

    // Write burst at 0x00.
    frame_start();
    xfer(8'h80, rx);
    xfer(8'hA5, rx);
    xfer(8'h3C, rx);
    frame_end();
    chk("wr_cfg0", {24'b0, cfg[7:0]}, 32'hA5);
    chk("wr_cfg1", {24'b0, cfg[15:8]}, 32'h3C);
    chk("wr_cfg_hi", {16'b0, cfg[31:16]}, 32'h0);
    chk("wr_strobes", strobe_cnt, 2);
    chk("wr_addr_log0", {25'b0, addr_log[0]}, 32'h0);
    chk("wr_addr_log1", {25'b0, addr_log[1]}, 32'h1);

    // Speed snapshot: MSB read freezes the value; later input changes are not seen.
    frame_start();
    xfer(8'h11, rx);
    xfer(8'h00, rx);
    chk("snap_msb", {24'b0, rx}, 32'h12);
    speed[15:0] = 16'hFFFF;
    xfer(8'h00, rx);
    chk("snap_lsb", {24'b0, rx}, 32'h34);
    xfer(8'h00, rx);
    chk("unmapped_13", {24'b0, rx}, 32'h00);
    frame_end();

    // Channel 1 burst: dir, speed MSB, speed LSB.
    frame_start();
    xfer(8'h20, rx);
    xfer(8'h00, rx);
    chk("ch1_dir", {24'b0, rx}, 32'h01);
    xfer(8'h00, rx);
    chk("ch1_msb", {24'b0, rx}, 32'hBE);
    xfer(8'h00, rx);
    chk("ch1_lsb", {24'b0, rx}, 32'hEF);
    frame_end();

    // Status then channel 0 dir.
    frame_start();
    xfer(8'h0F, rx);
    chk("cmd_sdo_zero", {24'b0, rx}, 32'h00);
    xfer(8'h00, rx);
    chk("status", {24'b0, rx}, 32'h5A);
    xfer(8'h00, rx);
    chk("ch0_dir", {24'b0, rx}, 32'h00);
    frame_end();

    // Unmapped read just above the config bank.
    frame_start();
    xfer(8'h05, rx);
    xfer(8'h00, rx);
    chk("unmapped_05", {24'b0, rx}, 32'h00);
    frame_end();

    // Config readback burst.
    frame_start();
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    chk("rd_cfg0", {24'b0, rx}, 32'hA5);
    xfer(8'h00, rx);
    chk("rd_cfg1", {24'b0, rx}, 32'h3C);
    frame_end();

    // Write to read-only status is ignored.
    s0 = strobe_cnt;
    frame_start();
    xfer(8'h8F, rx);
    xfer(8'hEE, rx);
    frame_end();
    chk("ro_no_strobe", strobe_cnt - s0, 0);

    // Address wrap 0x7F -> 0x00.
    s0 = strobe_cnt;
    frame_start();
    xfer(8'hFF, rx);
    xfer(8'h11, rx);
    xfer(8'h77, rx);
    frame_end();
    chk("wrap_cfg", cfg, 32'h00003C77);
    chk("wrap_strobes", strobe_cnt - s0, 1);
    chk("wrap_addr", {25'b0, addr_log[addr_log.size()-1]}, 32'h0);

    // Aborted write after 5 data bits.
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    frame_start();
    xfer(8'h81, rx);
    xfer_bits(8'h99, 5, rx);
    frame_end();
    chk("abort_cfg1", {24'b0, cfg[15:8]}, 32'h3C);
    chk("abort_ferr", ferr_cnt - f0, 1);
    chk("abort_no_strobe", strobe_cnt - s0, 0);
    frame_start();
    xfer(8'h81, rx);
    xfer(8'hC3, rx);
    frame_end();
    chk("after_abort_cfg1", {24'b0, cfg[15:8]}, 32'hC3);
    chk("after_abort_addr", {25'b0, wr_addr}, 32'h1);
    chk("after_abort_ferr", ferr_cnt - f0, 1);

    // Reset during a status read, one data bit in.
    frame_start();
    xfer(8'h0F, rx);
    xfer_bits(8'h00, 1, rx);
    tick(4);
    chk("pre_rst_sdo", {31'b0, spi_sdo}, 32'h1);
    theReset_n = 1'b0;
    #1;
    chk("midrst_sdo", {31'b0, spi_sdo}, 32'h0);
    chk("midrst_cfg", cfg, 32'h0);
    chk("midrst_wr_addr", {25'b0, wr_addr}, 32'h0);
    chk("midrst_strobe", {31'b0, wr_strobe}, 32'h0);
    chk("midrst_ferr", {31'b0, frame_err}, 32'h0);
    chk("midrst_state", {30'b0, dut.state_q}, {30'b0, spi_reg_pkg::S_IDLE});
    spi_cs = 1'b1;
    tick(4);
    theReset_n = 1'b1;
    tick(6);

    // Shadow is cleared by reset; then a fresh MSB read captures the live value.
    frame_start();
    xfer(8'h12, rx);
    xfer(8'h00, rx);
    chk("shadow_rst", {24'b0, rx}, 32'h00);
    frame_end();
    frame_start();
    xfer(8'h11, rx);
    xfer(8'h00, rx);
    chk("resnap_msb", {24'b0, rx}, 32'hFF);
    xfer(8'h00, rx);
    chk("resnap_lsb", {24'b0, rx}, 32'hFF);
    frame_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
